// File: rtl/lsu_bus_ctrl_pkg.sv
// lsu_bus_ctrl_pkg: shared widths, state codes, access-size encodings and alignment check
package lsu_bus_ctrl_pkg;
  localparam int XLEN = 32;
  localparam logic [7:0] TIMEOUT = 8'd255;
  localparam logic [1:0] SWHB_W = 2'b01;
  localparam logic [1:0] SWHB_H = 2'b10;
  localparam logic [1:0] SWHB_B = 2'b11;
  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;
  function automatic logic misaligned(input logic [1:0] swhb, input logic [1:0] off);
    return (swhb == SWHB_W && off != 2'b00) || (swhb == SWHB_H && off[0]);
  endfunction
endpackage

// File: rtl/lsu_bus_ctrl_if.sv
// lsu_bus_ctrl_if: req/gnt/rvalid data-bus channel between the LSU and memory
interface lsu_bus_ctrl_if;
  import lsu_bus_ctrl_pkg::*;
  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;
  modport master(output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave(input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/ampattern.sv
// ampattern: byte-enable pattern from access size and low address bits
module ampattern
  import lsu_bus_ctrl_pkg::*;
(
  input  logic [1:0] addr,
  input  logic [1:0] swhb,
  output logic [3:0] amp
);
  assign amp = swhb == SWHB_W ? 4'b1111 :
               swhb == SWHB_H ? (addr[1] ? 4'b1100 : 4'b0011) :
               swhb == SWHB_B ? 4'b0001 << addr : 4'b0000;
endmodule

// File: rtl/lsu_bus_ctrl_load_ext.sv
// lsu_bus_ctrl_load_ext: selects the addressed byte/half of a read word and sign/zero-extends it
module lsu_bus_ctrl_load_ext
  import lsu_bus_ctrl_pkg::*;
(
  input  logic [1:0]      off,
  input  logic [1:0]      swhb,
  input  logic            uns,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] res
);
  logic [XLEN-1:0] sh;
  logic [7:0]      b;
  logic [15:0]     h;
  assign sh = word >> {off, 3'b000};
  assign b = sh[7:0];
  assign h = off[1] ? word[31:16] : word[15:0];
  assign res = swhb == SWHB_B ? {{24{~uns & b[7]}}, b} :
               swhb == SWHB_H ? {{16{~uns & h[15]}}, h} : word;
endmodule

// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl: MEM-stage load/store controller driving a req/gnt/rvalid data bus
module lsu_bus_ctrl
  import lsu_bus_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req,
  input  logic            we,
  input  logic [1:0]      swhb,
  input  logic            lunsigned,
  input  logic            flush,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] rdata,
  output logic            misalign,
  output logic            buserr,
  lsu_bus_ctrl_if.master  bus
);
  lsu_state_e      state, state_nx;
  logic [7:0]      cnt;
  logic [XLEN-1:0] c_addr, c_wdata, rword, ext;
  logic [1:0]      c_swhb;
  logic            c_we, c_uns, flushed, berr;
  logic            mis, accept, tmo, busy;
  logic [3:0]      be;
  assign mis = misaligned(swhb, addr[1:0]);
  assign accept = state == LSU_IDLE && req && !flush && !mis;
  assign busy = state == LSU_REQ || state == LSU_WAIT;
  assign tmo = busy && cnt == TIMEOUT;
  always_comb begin
    state_nx = state;
    unique case (state)
      LSU_IDLE: state_nx = accept ? LSU_REQ : LSU_IDLE;
      LSU_REQ:
        if (tmo) state_nx = flush ? LSU_IDLE : LSU_DONE;
        else if (bus.gnt) state_nx = !c_we ? LSU_WAIT : flush ? LSU_IDLE : LSU_DONE;
        else if (flush) state_nx = LSU_IDLE;
      LSU_WAIT:
        if (tmo || bus.rvalid) state_nx = (flushed || flush) ? LSU_IDLE : LSU_DONE;
      LSU_DONE: state_nx = LSU_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= LSU_IDLE;
      cnt     <= 8'd0;
      c_addr  <= '0;
      c_wdata <= '0;
      c_swhb  <= 2'b00;
      c_we    <= 1'b0;
      c_uns   <= 1'b0;
      rword   <= '0;
      flushed <= 1'b0;
      berr    <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        c_addr  <= addr;
        c_wdata <= wdata;
        c_swhb  <= swhb;
        c_we    <= we;
        c_uns   <= lunsigned;
        cnt     <= 8'd0;
        flushed <= 1'b0;
        berr    <= 1'b0;
      end else if (busy) cnt <= cnt + 8'd1;
      if (flush && state_nx == LSU_WAIT) flushed <= 1'b1;
      if (state == LSU_WAIT && bus.rvalid) rword <= bus.rdata;
      if (tmo) berr <= 1'b1;
    end
  // Bus-side fields come only from the capture regs so they stay stable until gnt
  ampattern u_amp (.addr(c_addr[1:0]), .swhb(c_swhb), .amp(be));
  lsu_bus_ctrl_load_ext u_ext (.off(c_addr[1:0]), .swhb(c_swhb), .uns(c_uns), .word(rword), .res(ext));
  assign bus.req = state == LSU_REQ && !tmo;
  assign bus.we = bus.req && c_we;
  assign bus.addr = {c_addr[XLEN-1:2], 2'b00};
  assign bus.be = be;
  assign bus.wdata = c_swhb == SWHB_B ? {4{c_wdata[7:0]}} :
                     c_swhb == SWHB_H ? {2{c_wdata[15:0]}} : c_wdata;
  assign stall = accept || busy;
  assign done = state == LSU_DONE;
  assign buserr = done && berr;
  assign rdata = (done && !berr && !c_we) ? ext : '0;
  assign misalign = state == LSU_IDLE && req && !flush && mis;
endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// tb_lsu_bus_ctrl: directed vectors with queued expectations checked by bus/done monitors
module tb_lsu_bus_ctrl;
  import lsu_bus_ctrl_pkg::*;
  logic clk = 0, rst_n = 0, req = 0, we = 0, lunsigned = 0, flush = 0;
  logic [1:0] swhb = 2'b00;
  logic [31:0] addr = 0, wdata = 0, rdata;
  logic stall, done, misalign, buserr;
  int n_cmp = 0, n_err = 0;
  logic [68:0] bus_q[$];
  logic [32:0] done_q[$];
  lsu_bus_ctrl_if bus();
  lsu_bus_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .swhb(swhb), .lunsigned(lunsigned),
    .flush(flush), .addr(addr), .wdata(wdata), .stall(stall), .done(done), .rdata(rdata),
    .misalign(misalign), .buserr(buserr), .bus(bus.master)
  );
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (rst_n) begin
      if (bus.req && bus.gnt) begin
        if (bus_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL bus_unexpected: got %h expected none", {bus.we, bus.addr, bus.be, bus.wdata});
        end else chk("bus_xfer", {bus.we, bus.addr, bus.be, bus.wdata}, bus_q.pop_front());
      end
      if (done) begin
        if (done_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL done_unexpected: got %h expected none", {buserr, rdata});
        end else chk("done_resp", 69'({buserr, rdata}), 69'(done_q.pop_front()));
      end
    end

  task automatic run(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                     input logic [31:0] wd, input int gd, input int rd, input logic [31:0] rw,
                     input logic [31:0] ea, input logic [3:0] ebe, input logic [31:0] ewd,
                     input logic [31:0] erd);
    bus_q.push_back({w, ea, ebe, ewd});
    done_q.push_back({1'b0, erd});
    req = 1; we = w; swhb = sz; lunsigned = u; addr = a; wdata = wd;
    @(negedge clk); chk("accept_stall", 69'(stall), 69'(1));
    @(posedge clk); #1;
    addr = ~a; wdata = ~wd; lunsigned = ~u; swhb = ~sz;
    repeat (gd) begin @(posedge clk); #1; end
    bus.gnt = 1;
    if (!w) begin bus.rvalid = 1; bus.rdata = ~rw; end
    @(posedge clk); #1;
    bus.gnt = 0; bus.rvalid = 0;
    if (!w) begin
      repeat (rd - 1) begin @(posedge clk); #1; end
      bus.rvalid = 1; bus.rdata = rw;
      @(posedge clk); #1;
      bus.rvalid = 0;
    end
    @(negedge clk); chk("done_after_access", 69'(done), 69'(1));
    req = 0; we = 0; lunsigned = 0; swhb = 2'b00;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

  initial begin
    int reqc, sc;
    bit seen;
    bus.gnt = 0; bus.rvalid = 0; bus.rdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_stall_done", 69'({stall, done, misalign, buserr}), 69'(0));
    chk("rst_rdata", 69'(rdata), 69'(0));
    chk("rst_bus", {bus.we, bus.addr, bus.be, bus.wdata}, 69'(0));
    chk("rst_bus_req", 69'(bus.req), 69'(0));
    @(posedge clk); #1; rst_n = 1;
    @(posedge clk); #1;
    // w sz u addr wdata gd rd rword | exp addr be wdata rdata
    run(1, SWHB_W, 0, 32'h80000104, 32'h12345678, 0, 0, 0, 32'h80000104, 4'b1111, 32'h12345678, 0);
    run(0, SWHB_B, 0, 32'h80000103, 0, 0, 2, 32'h80FFFF00, 32'h80000100, 4'b1000, 0, 32'hFFFFFF80);
    run(0, SWHB_B, 1, 32'h80000103, 0, 1, 2, 32'h80FFFF00, 32'h80000100, 4'b1000, 0, 32'h00000080);
    run(1, SWHB_H, 0, 32'h80000102, 32'h0000BEEF, 2, 0, 0, 32'h80000100, 4'b1100, 32'hBEEFBEEF, 0);
    run(1, SWHB_B, 0, 32'h80000011, 32'h000000A5, 1, 0, 0, 32'h80000010, 4'b0010, 32'hA5A5A5A5, 0);
    run(0, SWHB_H, 0, 32'h80000202, 0, 0, 1, 32'h80FF1234, 32'h80000200, 4'b1100, 0, 32'hFFFF80FF);
    run(0, SWHB_H, 1, 32'h80000202, 0, 0, 1, 32'h80FF1234, 32'h80000200, 4'b1100, 0, 32'h000080FF);
    run(0, SWHB_W, 0, 32'h80000300, 0, 3, 1, 32'hDEADBEEF, 32'h80000300, 4'b1111, 0, 32'hDEADBEEF);
    run(0, SWHB_B, 0, 32'h80000001, 0, 0, 3, 32'h00007F00, 32'h80000000, 4'b0010, 0, 32'h0000007F);
    run(0, SWHB_H, 0, 32'h80000000, 0, 1, 1, 32'h12348001, 32'h80000000, 4'b0011, 0, 32'hFFFF8001);
    // misaligned word / half, and a flushed misaligned access
    req = 1; we = 0; swhb = SWHB_W; addr = 32'h80000101;
    @(negedge clk);
    chk("mis_word", 69'({misalign, stall, bus.req}), 69'(3'b100));
    @(posedge clk); #1; swhb = SWHB_H; addr = 32'h80000103;
    @(negedge clk);
    chk("mis_half", 69'({misalign, stall, bus.req}), 69'(3'b100));
    @(posedge clk); #1; flush = 1;
    @(negedge clk);
    chk("mis_flushed", 69'({misalign, stall}), 69'(0));
    @(posedge clk); #1; req = 0; flush = 0;
    @(negedge clk);
    chk("mis_no_access", 69'({misalign, stall, bus.req}), 69'(0));
    // timeout: gnt never arrives
    done_q.push_back({1'b1, 32'h0});
    @(posedge clk); #1; req = 1; we = 0; swhb = SWHB_W; addr = 32'h80000400;
    reqc = 0; seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (bus.req) reqc++;
      if (done) seen = 1;
    end
    chk("timeout_done_seen", 69'(seen), 69'(1));
    chk("timeout_req_cycles", 69'(reqc), 69'(255));
    req = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("timeout_idle", 69'({stall, done}), 69'(0));
    // flush during WAIT: drain rvalid, no done
    bus_q.push_back({1'b0, 32'h80000500, 4'b1111, 32'h0});
    @(posedge clk); #1; req = 1; we = 0; swhb = SWHB_W; addr = 32'h80000500; wdata = 0;
    @(posedge clk); #1; bus.gnt = 1;
    @(posedge clk); #1; bus.gnt = 0; flush = 1;
    sc = 0;
    @(negedge clk); sc += int'(stall);
    @(posedge clk); #1; flush = 0; req = 0;
    @(negedge clk); sc += int'(stall);
    @(posedge clk); #1;
    @(negedge clk); sc += int'(stall);
    @(posedge clk); #1; bus.rvalid = 1; bus.rdata = 32'h11111111;
    @(negedge clk); sc += int'(stall);
    @(posedge clk); #1; bus.rvalid = 0;
    @(negedge clk);
    chk("flush_wait_stall_cycles", 69'(sc), 69'(4));
    chk("flush_wait_drained", 69'({stall, done}), 69'(0));
    // flush in REQ before gnt
    @(posedge clk); #1; req = 1; we = 0; swhb = SWHB_W; addr = 32'h80000600;
    @(posedge clk); #1; flush = 1;
    @(negedge clk);
    chk("flush_req_still_req", 69'(bus.req), 69'(1));
    @(posedge clk); #1; flush = 0; req = 0;
    @(negedge clk);
    chk("flush_req_dropped", 69'({bus.req, stall, done}), 69'(0));
    // store flushed coincident with gnt: write still happens, no done
    bus_q.push_back({1'b1, 32'h80000700, 4'b1111, 32'hCAFEF00D});
    @(posedge clk); #1; req = 1; we = 1; swhb = SWHB_W; addr = 32'h80000700; wdata = 32'hCAFEF00D;
    @(posedge clk); #1; bus.gnt = 1; flush = 1;
    @(posedge clk); #1; bus.gnt = 0; flush = 0; req = 0; we = 0;
    @(negedge clk);
    chk("flush_gnt_store_idle", 69'({stall, done}), 69'(0));
    // asynchronous reset in the middle of REQ
    @(posedge clk); #1; req = 1; we = 0; swhb = SWHB_W; addr = 32'h80000800;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_reset_req", 69'(bus.req), 69'(1));
    #2; rst_n = 0; #1;
    chk("reset_drops_req", 69'(bus.req), 69'(0));
    req = 0;
    @(posedge clk); #1; rst_n = 1;
    repeat (3) @(negedge clk);
    chk("bus_q_empty", 69'(bus_q.size()), 69'(0));
    chk("done_q_empty", 69'(done_q.size()), 69'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
